regfile_seq_engine: RTL
=======================

# regfile_seq_engine

Parametrised register-file sequencer with its own register bank and ALU slice. On a start handshake it seeds r0/r1, then walks r2..r[NREGS-1], writing r[i] = op(r[i-1], r[i-2]) one register per cycle in one of four latched modes. It accumulates sticky carry and overflow flags, pulses done, and exposes a registered readback port for the display/test harness. It is the bring-up engine for datapath and register-file validation on the board.

## Interface
- WIDTH, 16, data width in bits (≥4)
- NREGS, 16, register count (3..256); AW = clog2(NREGS) derived
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low (0 = reset)
- start  in  1  request; accepted only in IDLE
- mode  in  2  00 ADD, 01 SUB, 10 XOR, 11 ADDC; latched on accept
- seed0, seed1  in  WIDTH  initial r0/r1 values; latched on accept
- busy  out  1  high from LOAD0 through last STEP
- done  out  1  one-cycle pulse in DONE
- state  out  3  current FSM state code (debug/LED)
- wr_onehot  out  NREGS  one-hot write enable of current cycle (monitor)
- carry_sticky  out  1  OR of per-step carry/borrow
- ovf_sticky  out  1  OR of per-step signed overflow
- rd_addr  in  AW  readback address
- rd_data  out  WIDTH  registered readback value

## Operation
- States: IDLE(0) → LOAD0(1) → LOAD1(2) → STEP(3) → DONE(4) → IDLE.
- IDLE: start=1 at an edge → latch mode/seeds, clear both sticky flags, go to LOAD0.
- LOAD0 writes r0 = seed0; LOAD1 writes r1 = seed1, sets idx = 2.
- STEP: A = r[idx-1], B = r[idx-2]; write r[idx]; idx++; leave STEP after writing idx = NREGS-1.
- ADD: A+B, cin=0. ADDC: A+B+c, c = carry-out of previous step (0 on first step). SUB: A−B, carry flag = borrow (A<B unsigned). XOR: A^B, no flags.
- Results truncate to WIDTH (mod 2^WIDTH). Signed overflow for ADD/ADDC/SUB uses the standard two's-complement rule. Sticky flags OR in per step.
- start while not IDLE is ignored; latched mode/seeds do not change.
- rd_addr ≥ NREGS returns 0.

## Timing
- Reset (asynchronous, any state including mid-STEP): state=IDLE, all registers, idx, sticky flags, rd_data = 0; busy=0, done=0, wr_onehot=0.
- Start sampled at edge k: r0 written at edge k+1, r1 at k+2, r[i] at edge k+i+1.
- done is high for exactly the cycle after edge k+NREGS; busy is low in that cycle.
- The earliest next start is accepted at edge k+NREGS+2 (in IDLE).
- wr_onehot is combinational from state/idx and is high during the cycle whose closing edge performs the write.
- rd_data has one-cycle latency. A read and a write to the same register on the same edge returns the old value.
- Flags are valid from the cycle after the step's write edge.

## Structure
- Package regseq_pkg: state encodings, mode constants (MODE_ADD/SUB/XOR/ADDC), state width.
- Sub-module regfile_bank: NREGS×WIDTH with one write port, two combinational read ports (A,B) and one registered read port, plus async active-low clear.
- The FSM, index counter, ALU slice and flag logic live in the top module.

## Test plan
- WIDTH=16, ADD, seeds 1,1 → r15=0x03DB (987), r2=2; carry_sticky=0, ovf_sticky=0; done 17 cycles after start edge.
- WIDTH=8, ADD, seeds 1,1 → r11=0x90 (first signed overflow), r13=0x79 (first carry), r15=0xDB; both sticky flags set.
- SUB, seeds 5,3 → r2=0xFFFE, carry_sticky=1.
- XOR, seeds 0x00FF,0x0F0F → r2=0x0FF0, r3=0x00FF, r15=0x00FF; flags 0.
- Assert reset in STEP at idx=7 → same-cycle IDLE, busy=0, all reads 0. A fresh start then completes normally.
- Pulse start with mode=XOR mid-run of an ADD → ignored; ADD results unchanged. Start held high through DONE → a second run begins from IDLE with flags cleared.

Source files
------------

// File: rtl/regfile_seq_engine_pkg.sv
// Shared encodings for the register-file sequencer: FSM state codes and ALU modes.
package regseq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD0 = 3'd1,
    ST_LOAD1 = 3'd2,
    ST_STEP  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [1:0] MODE_ADD  = 2'b00;
  localparam logic [1:0] MODE_SUB  = 2'b01;
  localparam logic [1:0] MODE_XOR  = 2'b10;
  localparam logic [1:0] MODE_ADDC = 2'b11;

endpackage

// File: rtl/regfile_seq_engine_if.sv
// Control, status and readback bundle between the sequencer and its harness.
interface regfile_seq_engine_if
  import regseq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 16
);
  localparam int AW = $clog2(NREGS);

  logic               start;
  logic [1:0]         mode;
  logic [WIDTH-1:0]   seed0;
  logic [WIDTH-1:0]   seed1;
  logic               busy;
  logic               done;
  logic [STATE_W-1:0] state;
  logic [NREGS-1:0]   wr_onehot;
  logic               carry_sticky;
  logic               ovf_sticky;
  logic [AW-1:0]      rd_addr;
  logic [WIDTH-1:0]   rd_data;

  modport master (
    output start, mode, seed0, seed1, rd_addr,
    input  busy, done, state, wr_onehot, carry_sticky, ovf_sticky, rd_data
  );

  modport slave (
    input  start, mode, seed0, seed1, rd_addr,
    output busy, done, state, wr_onehot, carry_sticky, ovf_sticky, rd_data
  );

endinterface

// File: rtl/regfile_seq_engine_bank.sv
// NREGS x WIDTH register bank: one write port, two combinational operand reads,
// one registered readback port; everything clears on reset.
module regfile_bank
  import regseq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 16,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr_a,
  input  logic [AW-1:0]    i_raddr_b,
  output logic [WIDTH-1:0] o_rdata_a,
  output logic [WIDTH-1:0] o_rdata_b,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [NREGS];
  logic [WIDTH-1:0] r_rd_data;

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];
  assign o_rd_data = r_rd_data;

  // Readback samples the pre-write contents, so a same-edge read sees the old value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
      r_rd_data <= '0;
    end else begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      r_rd_data <= (int'(i_rd_addr) < NREGS) ? r_mem[i_rd_addr] : '0;
    end
  end

endmodule

// File: rtl/regfile_seq_engine.sv
// Sequencer: seeds r0/r1, then fills r[i] = op(r[i-1], r[i-2]) one register
// per cycle, accumulating sticky carry/borrow and signed-overflow flags.
module regfile_seq_engine
  import regseq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 16
) (
  input logic            clk,
  input logic            reset,
  regfile_seq_engine_if.slave bus
);

  localparam int AW = $clog2(NREGS);

  state_e           r_state, w_next;
  logic [AW-1:0]    r_idx;
  logic [1:0]       r_mode;
  logic [WIDTH-1:0] r_seed0, r_seed1;
  logic             r_carry, r_ovf, r_cprev;

  logic             w_we, w_load_cfg, w_step;
  logic [AW-1:0]    w_waddr;
  logic [WIDTH-1:0] w_wdata, w_a, w_b, w_alu_res;
  logic [WIDTH:0]   w_sum, w_diff;
  logic             w_cin, w_cout, w_vout;

  regfile_bank #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) u_bank (
    .clk       (clk),
    .reset     (reset),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr_a (r_idx - AW'(1)),
    .i_raddr_b (r_idx - AW'(2)),
    .o_rdata_a (w_a),
    .o_rdata_b (w_b),
    .i_rd_addr (bus.rd_addr),
    .o_rd_data (bus.rd_data)
  );

  // Borrow is the extra top bit of the zero-extended subtraction.
  always_comb begin
    w_cin     = (r_mode == MODE_ADDC) ? r_cprev : 1'b0;
    w_sum     = {1'b0, w_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_cin};
    w_diff    = {1'b0, w_a} - {1'b0, w_b};
    w_alu_res = w_sum[WIDTH-1:0];
    w_cout    = w_sum[WIDTH];
    w_vout    = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_alu_res[WIDTH-1] != w_a[WIDTH-1]);
    case (r_mode)
      MODE_SUB: begin
        w_alu_res = w_diff[WIDTH-1:0];
        w_cout    = w_diff[WIDTH];
        w_vout    = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_alu_res[WIDTH-1] != w_a[WIDTH-1]);
      end
      MODE_XOR: begin
        w_alu_res = w_a ^ w_b;
        w_cout    = 1'b0;
        w_vout    = 1'b0;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_next     = r_state;
    w_we       = 1'b0;
    w_waddr    = r_idx;
    w_wdata    = '0;
    w_load_cfg = 1'b0;
    w_step     = 1'b0;
    case (r_state)
      ST_IDLE: if (bus.start) begin
        w_next     = ST_LOAD0;
        w_load_cfg = 1'b1;
      end
      ST_LOAD0: begin
        w_we    = 1'b1;
        w_waddr = '0;
        w_wdata = r_seed0;
        w_next  = ST_LOAD1;
      end
      ST_LOAD1: begin
        w_we    = 1'b1;
        w_waddr = AW'(1);
        w_wdata = r_seed1;
        w_next  = ST_STEP;
      end
      ST_STEP: begin
        w_we    = 1'b1;
        w_step  = 1'b1;
        w_wdata = w_alu_res;
        if (r_idx == AW'(NREGS - 1)) w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx   <= '0;
      r_mode  <= MODE_ADD;
      r_seed0 <= '0;
      r_seed1 <= '0;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
      r_cprev <= 1'b0;
    end else begin
      if (w_load_cfg) begin
        r_mode  <= bus.mode;
        r_seed0 <= bus.seed0;
        r_seed1 <= bus.seed1;
        r_carry <= 1'b0;
        r_ovf   <= 1'b0;
        r_cprev <= 1'b0;
      end
      if (r_state == ST_LOAD1) r_idx <= AW'(2);
      if (w_step) begin
        r_idx   <= r_idx + AW'(1);
        r_carry <= r_carry | w_cout;
        r_ovf   <= r_ovf | w_vout;
        r_cprev <= w_cout;
      end
    end
  end

  assign bus.busy         = (r_state == ST_LOAD0) || (r_state == ST_LOAD1) || (r_state == ST_STEP);
  assign bus.done         = (r_state == ST_DONE);
  assign bus.state        = r_state;
  assign bus.wr_onehot    = w_we ? (NREGS'(1) << w_waddr) : '0;
  assign bus.carry_sticky = r_carry;
  assign bus.ovf_sticky   = r_ovf;

endmodule
